fifo_wr_arbiter: RTL and testbench
==================================

# fifo_wr_arbiter

Round-robin write arbiter that shares the single write port of one `fifo` instance among `NUM_REQ` producers. It sits directly in front of the FIFO, accepts one word per cycle from the current owner, and lets that owner keep the port for a burst of up to `MAX_BURST` words. Admission is gated by a credit check on the FIFO's occupancy count, so the FIFO's own full-drop path never fires. All FIFO-facing outputs are registered.

## Interface
- `NUM_REQ`, default 4: number of requesters, minimum 2.
- `FIFO_WIDTH`, default 8: data width, equal to the FIFO's `FIFO_WIDTH`.
- `FIFO_DEPTH`, default 8: FIFO depth, a power of two, equal to the FIFO's `FIFO_DEPTH`.
- `MAX_BURST`, default 4: maximum consecutive words per ownership, minimum 1.
- `clk` input, 1 bit: the single clock; all state changes on the rising edge.
- `reset` input, 1 bit: synchronous, active-low reset.
- `req` input, `NUM_REQ` bits: per-requester valid; `req[i]` qualifies word i of `reqData`.
- `reqData` input, `NUM_REQ*FIFO_WIDTH` bits: requester i's word occupies bits `[i*FIFO_WIDTH +: FIFO_WIDTH]`.
- `gnt` output, `NUM_REQ` bits: combinational accept; one-hot or zero. `gnt[i]`=1 means requester i's word is consumed at this edge.
- `fifoWrEn` output, 1 bit: registered; drives the FIFO's `fifoWrEn`.
- `fifoWrData` output, `FIFO_WIDTH` bits: registered; drives the FIFO's `fifoWrData`.
- `fifoDataCount` input, `$clog2(FIFO_DEPTH)+1` bits: the FIFO's occupancy.
- `busy` output, 1 bit: registered; 1 while in state BURST.
- `owner` output, `$clog2(NUM_REQ)` bits: registered; index of the last accepted requester.

## Operation
- Space check:
  - `space = (fifoDataCount + fifoWrEn) < FIFO_DEPTH`, computed at `$clog2(FIFO_DEPTH)+2` bits so there is no overflow.
  - The `fifoWrEn` term counts the word that is registered but not yet reflected in `fifoDataCount`.
  - Reads can only lower the count, so the check is conservative.
- `rrPtr` register, `$clog2(NUM_REQ)` bits, reset value 0: the first index searched in IDLE.
- `burstCnt` register, `$clog2(MAX_BURST)+1` bits, reset value 0.
- State IDLE:
  - If any `req` and `space`: the winner is the first set `req[i]` searching `rrPtr`, `rrPtr+1`, …, wrapping modulo `NUM_REQ`.
  - Assert `gnt[winner]` and set `owner=winner`, `burstCnt=1`.
  - If `MAX_BURST`==1: stay in IDLE and set `rrPtr=winner+1`. Otherwise go to BURST.
  - If there is no `req`, or `space`=0: no `gnt`, stay in IDLE.
- State BURST:
  - `req[owner]` and `space`:
    - Assert `gnt[owner]` and increment `burstCnt`.
    - If the new `burstCnt`==`MAX_BURST`: go to IDLE and set `rrPtr=owner+1` (wrapping).
  - `req[owner]` and not `space`: no `gnt`; hold the state, the owner and `burstCnt`.
  - `req[owner]`=0:
    - Go to IDLE and set `rrPtr=owner+1`; no `gnt` this cycle (one bubble).
    - Other requesters are ignored during BURST.
- On any `gnt[i]`: next cycle `fifoWrEn`=1 and `fifoWrData`=the word of requester i.
- With no `gnt`: next cycle `fifoWrEn`=0 and `fifoWrData` holds its previous value.
- Reset (`reset`=0 at an edge):
  - State IDLE; `rrPtr`, `burstCnt`, `owner` = 0; `fifoWrEn`=0; `fifoWrData`=0; `busy`=0.
  - `gnt` is forced to 0 combinationally while `reset`=0.
  - Reset mid-burst abandons the burst. Words already granted are lost only if the FIFO is reset too; the bench resets both together.

## Timing
- Accept-to-FIFO latency: `gnt` in cycle t gives `fifoWrEn` high in cycle t+1. The FIFO's own internal pipeline adds its latency after that.
- Sustained throughput is 1 word/cycle within a burst while `space`=1.
- Switching requesters after a burst ended by the limit costs 0 bubbles: IDLE arbitrates in the next cycle.
- A burst ended by `req` deassertion costs 1 bubble.
- Requesters hold `req` and `reqData` stable until `gnt`. Dropping `req` without `gnt` is allowed and only forfeits ownership.
- `gnt` depends combinationally on `req`, state and `fifoDataCount`. There is no path from `gnt` back to `req` inside this block.
- Fairness bound: a continuously requesting input is granted within `(NUM_REQ-1)*(MAX_BURST+1)` cycles of non-full operation.

## Test plan
- **Reset:** hold `reset`=0 for 3 cycles with all `req`=1 -> `gnt`=0, `fifoWrEn`=0, `fifoWrData`=0, `busy`=0, `owner`=0.
- **Round-robin with bursts:** defaults, all 4 requesters continuously valid, FIFO drained every cycle -> grant order 0×4, 1×4, 2×4, 3×4, 0×4, … with no bubbles. FIFO output sequence matches the words driven by each requester.
- **Full backpressure:** no reads, requester 1 streams 10 words -> exactly 8 `gnt`. `gnt` is low once `fifoDataCount`+`fifoWrEn` reaches 8, FIFO `fifoFull`=1, and no word is dropped. One read then releases exactly one further `gnt`.
- **Early release and wrap:** requester 3 sends 2 words, then drops `req` while requester 0 is waiting -> one bubble cycle, then `gnt[0]`. `rrPtr` has wrapped from 3 to 0.
- **`MAX_BURST`=1:** `NUM_REQ`=3, all `req`=1 -> `gnt` rotates 0,1,2,0,… every cycle and `busy` stays 0.
- **Reset mid-burst:** `reset`=0 at the second word of a burst from requester 2 -> the next cycle has `busy`=0 and `gnt`=0. After release, arbitration restarts from requester 0.

Source files
------------

// File: rtl/fifo_wr_arbiter_if.sv
// Bundle of requester-side and FIFO-write-side signals around fifo_wr_arbiter.
// The master modport is the arbiter. The slave modport is the requesters plus the FIFO.
interface fifo_wr_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int FIFO_WIDTH = 8,
    parameter int FIFO_DEPTH = 8
);
    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ*FIFO_WIDTH-1:0] reqData;
    logic [NUM_REQ-1:0]            gnt;
    logic                          fifoWrEn;
    logic [FIFO_WIDTH-1:0]         fifoWrData;
    logic [CNT_W-1:0]              fifoDataCount;
    logic                          busy;
    logic [PTR_W-1:0]              owner;

    modport master (
        input  req, reqData, fifoDataCount,
        output gnt, fifoWrEn, fifoWrData, busy, owner
    );

    modport slave (
        output req, reqData, fifoDataCount,
        input  gnt, fifoWrEn, fifoWrData, busy, owner
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter in front of a single FIFO write port.
// Admission is credit-gated on the FIFO occupancy, so the FIFO never sees a write while it is full.
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int FIFO_WIDTH = 8,
    parameter int FIFO_DEPTH = 8,
    parameter int MAX_BURST  = 4
) (
    input  logic              clk,
    input  logic              reset,
    fifo_wr_arbiter_if.master bus
);
    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int SPC_W = CNT_W + 1;
    localparam int BC_W  = $clog2(MAX_BURST) + 1;

    typedef enum logic {IDLE, BURST} state_t;

    state_t                stateReg;
    logic [PTR_W-1:0]      rrPtrReg;
    logic [PTR_W-1:0]      ownerReg;
    logic [BC_W-1:0]       burstCntReg;
    logic                  fifoWrEnReg;
    logic [FIFO_WIDTH-1:0] fifoWrDataReg;
    logic                  busyReg;

    logic [FIFO_WIDTH-1:0] reqWord [NUM_REQ];
    logic [SPC_W-1:0]      pending;
    logic                  space;
    logic                  found;
    logic [PTR_W-1:0]      winner;
    logic [PTR_W-1:0]      cand;
    int                    searchIdx;
    logic                  grantValid;
    logic [PTR_W-1:0]      grantIdx;
    logic [BC_W-1:0]       burstNext;
    logic                  lastBeat;

    function automatic logic [PTR_W-1:0] nextIdx(input logic [PTR_W-1:0] idx);
        return (int'(idx) == NUM_REQ - 1) ? '0 : idx + PTR_W'(1);
    endfunction

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign reqWord[gi] = bus.reqData[gi*FIFO_WIDTH +: FIFO_WIDTH];
            assign bus.gnt[gi] = grantValid && (grantIdx == PTR_W'(gi));
        end
    endgenerate

    // The registered write is not yet in fifoDataCount, so count it as already occupying a slot.
    assign pending = {1'b0, bus.fifoDataCount} + {{(SPC_W-1){1'b0}}, fifoWrEnReg};
    assign space   = pending < SPC_W'(FIFO_DEPTH);

    always_comb begin
        found     = 1'b0;
        winner    = '0;
        cand      = '0;
        searchIdx = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            searchIdx = int'(rrPtrReg) + k;
            if (searchIdx >= NUM_REQ) begin
                searchIdx = searchIdx - NUM_REQ;
            end
            cand = PTR_W'(searchIdx);
            if (!found && bus.req[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    always_comb begin
        grantValid = 1'b0;
        grantIdx   = winner;
        if (reset) begin
            if (stateReg == IDLE) begin
                grantValid = found && space;
                grantIdx   = winner;
            end else begin
                grantValid = bus.req[ownerReg] && space;
                grantIdx   = ownerReg;
            end
        end
    end

    assign burstNext = burstCntReg + BC_W'(1);
    assign lastBeat  = (burstNext == BC_W'(MAX_BURST));

    always_ff @(posedge clk) begin
        if (!reset) begin
            stateReg      <= IDLE;
            rrPtrReg      <= '0;
            ownerReg      <= '0;
            burstCntReg   <= '0;
            fifoWrEnReg   <= 1'b0;
            fifoWrDataReg <= '0;
            busyReg       <= 1'b0;
        end else begin
            fifoWrEnReg <= grantValid;
            if (grantValid) begin
                fifoWrDataReg <= reqWord[grantIdx];
            end
            case (stateReg)
                IDLE: begin
                    if (grantValid) begin
                        ownerReg    <= winner;
                        burstCntReg <= BC_W'(1);
                        if (MAX_BURST == 1) begin
                            rrPtrReg <= nextIdx(winner);
                        end else begin
                            stateReg <= BURST;
                            busyReg  <= 1'b1;
                        end
                    end
                end
                BURST: begin
                    // Other requesters are not looked at here; a stalled owner keeps the port.
                    if (bus.req[ownerReg]) begin
                        if (space) begin
                            burstCntReg <= burstNext;
                            if (lastBeat) begin
                                stateReg <= IDLE;
                                busyReg  <= 1'b0;
                                rrPtrReg <= nextIdx(ownerReg);
                            end
                        end
                    end else begin
                        stateReg <= IDLE;
                        busyReg  <= 1'b0;
                        rrPtrReg <= nextIdx(ownerReg);
                    end
                end
            endcase
        end
    end

    assign bus.fifoWrEn   = fifoWrEnReg;
    assign bus.fifoWrData = fifoWrDataReg;
    assign bus.busy       = busyReg;
    assign bus.owner      = ownerReg;
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter with a behavioural 8-deep FIFO model behind it.
// A second instance covers MAX_BURST=1 with three requesters.
module tb_fifo_wr_arbiter;
    logic clk;
    logic reset;
    logic reset2;
    logic rdEn;

    fifo_wr_arbiter_if #(.NUM_REQ(4), .FIFO_WIDTH(8), .FIFO_DEPTH(8)) bus ();
    fifo_wr_arbiter_if #(.NUM_REQ(3), .FIFO_WIDTH(8), .FIFO_DEPTH(8)) bus2 ();

    fifo_wr_arbiter #(.NUM_REQ(4), .FIFO_WIDTH(8), .FIFO_DEPTH(8), .MAX_BURST(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    fifo_wr_arbiter #(.NUM_REQ(3), .FIFO_WIDTH(8), .FIFO_DEPTH(8), .MAX_BURST(1)) dut2 (
        .clk   (clk),
        .reset (reset2),
        .bus   (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural FIFO: registered read data, occupancy count, drop counter.
    logic [7:0] mem [8];
    logic [2:0] wp, rp;
    logic [3:0] cnt;
    logic       rdValid;
    logic [7:0] rdData;
    int         dropped = 0;
    logic       wrOk, rdOk;

    assign wrOk = bus.fifoWrEn && (cnt != 4'd8);
    assign rdOk = rdEn && (cnt != 4'd0);
    assign bus.fifoDataCount  = cnt;
    assign bus2.fifoDataCount = 4'd0;

    always @(posedge clk) begin
        if (!reset) begin
            wp      <= '0;
            rp      <= '0;
            cnt     <= '0;
            rdValid <= 1'b0;
        end else begin
            if (wrOk) begin
                mem[wp] <= bus.fifoWrData;
                wp      <= wp + 3'd1;
            end
            if (bus.fifoWrEn && !wrOk) begin
                dropped <= dropped + 1;
            end
            if (rdOk) begin
                rdData <= mem[rp];
                rp     <= rp + 3'd1;
            end
            rdValid <= rdOk;
            cnt     <= cnt + 4'(wrOk) - 4'(rdOk);
        end
    end

    int         checks;
    int         failures;
    int         remain [4];
    int         seqNum [4];
    int         expSeq [4];
    logic [3:0] gS;
    int         expGnt [$];
    logic [7:0] expWr [$];
    logic [7:0] expRd [$];
    int         exp2Gnt [$];
    logic [7:0] exp2Wr [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h time=%0t", name, act, req, $time);
        end
    endtask

    // Hand-computed grant list: requester r's next n words, each word = r*64 + sequence number.
    task automatic expectWords(input int r, input int n, input bit toFifo);
        logic [7:0] w;
        for (int k = 0; k < n; k++) begin
            w = 8'(r * 64 + expSeq[r] % 64);
            expGnt.push_back(r);
            expWr.push_back(w);
            if (toFifo) expRd.push_back(w);
            expSeq[r]++;
        end
    endtask

    task automatic stepEdge();
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (gS[i]) begin
                seqNum[i]++;
                remain[i]--;
            end
        end
    endtask

    task automatic stepSample();
        for (int i = 0; i < 4; i++) begin
            bus.req[i]             = remain[i] > 0;
            bus.reqData[i*8 +: 8]  = 8'(i * 64 + seqNum[i] % 64);
        end
        @(negedge clk);
        gS = bus.gnt;
    endtask

    task automatic tick();
        stepEdge();
        stepSample();
    endtask

    initial begin : monitor
        int e;
        logic [7:0] w;
        forever begin
            @(negedge clk);
            if (bus.gnt != 0) begin
                $display("gnt vec=%b t=%0t", bus.gnt, $time);
                if (expGnt.size() == 0) begin
                    check("gnt_unexpected", 32'(bus.gnt), 0);
                end else begin
                    e = expGnt.pop_front();
                    check("gnt_order", 32'(bus.gnt), 32'(1) << e);
                end
            end
            if (bus.fifoWrEn === 1'b1) begin
                if (expWr.size() == 0) begin
                    check("wr_unexpected", 32'(bus.fifoWrData), 32'hFFFF);
                end else begin
                    w = expWr.pop_front();
                    check("wr_data", 32'(bus.fifoWrData), 32'(w));
                end
            end
            if (rdValid === 1'b1) begin
                if (expRd.size() == 0) begin
                    check("rd_unexpected", 32'(rdData), 32'hFFFF);
                end else begin
                    w = expRd.pop_front();
                    check("rd_data", 32'(rdData), 32'(w));
                end
            end
        end
    end

    initial begin : monitor2
        int e;
        logic [7:0] w;
        forever begin
            @(negedge clk);
            if (bus2.gnt != 0) begin
                $display("gnt2 vec=%b t=%0t", bus2.gnt, $time);
                if (exp2Gnt.size() == 0) begin
                    check("gnt2_unexpected", 32'(bus2.gnt), 0);
                end else begin
                    e = exp2Gnt.pop_front();
                    check("gnt2_order", 32'(bus2.gnt), 32'(1) << e);
                end
            end
            if (bus2.fifoWrEn === 1'b1) begin
                if (exp2Wr.size() == 0) begin
                    check("wr2_unexpected", 32'(bus2.fifoWrData), 32'hFFFF);
                end else begin
                    w = exp2Wr.pop_front();
                    check("wr2_data", 32'(bus2.fifoWrData), 32'(w));
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "bench timed out");
    end

    initial begin : stimulus
        int grants;
        int bubbles;
        int cyc;
        int n;
        logic [3:0] earlyExp [6];
        logic [7:0] w;

        checks   = 0;
        failures = 0;
        reset    = 1'b0;
        reset2   = 1'b0;
        rdEn     = 1'b1;
        gS       = '0;
        for (int i = 0; i < 4; i++) begin
            remain[i] = 8;
            seqNum[i] = 0;
            expSeq[i] = 0;
        end
        bus2.req     = 3'b111;
        bus2.reqData = 24'hC2B1A0;

        // Reset: three reset edges with every requester asserting.
        for (int rep = 0; rep < 2; rep++) begin
            for (int r = 0; r < 4; r++) expectWords(r, 4, 1'b1);
        end
        stepSample();
        tick();
        tick();
        check("rst_gnt", 32'(gS), 0);
        check("rst_wren", 32'(bus.fifoWrEn), 0);
        check("rst_wrdata", 32'(bus.fifoWrData), 0);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_owner", 32'(bus.owner), 0);

        // Round robin, 4-word bursts, drained FIFO.
        stepEdge();
        reset = 1'b1;
        stepSample();
        check("rr_first_gnt", 32'(gS), 32'h1);
        grants  = 0;
        bubbles = 0;
        cyc     = 0;
        while (grants < 32 && cyc < 100) begin
            if (gS != 0) grants++;
            else bubbles++;
            cyc++;
            if (grants < 32) tick();
        end
        check("rr_grants", grants, 32);
        check("rr_bubbles", bubbles, 0);
        repeat (12) tick();
        check("rr_fifo_empty", 32'(cnt), 0);
        check("rr_rd_left", expRd.size(), 0);

        // Full backpressure: requester 1 streams 10 words with no reads.
        stepEdge();
        rdEn      = 1'b0;
        remain[1] = 10;
        expectWords(1, 10, 1'b1);
        stepSample();
        grants = 0;
        repeat (16) begin
            if (gS != 0) grants++;
            if (32'(cnt) + 32'(bus.fifoWrEn) >= 8) check("full_gnt_low", 32'(gS), 0);
            tick();
        end
        check("full_grants", grants, 8);
        check("full_flag", 32'(cnt == 4'd8), 1);
        stepEdge();
        rdEn = 1'b1;
        stepSample();
        stepEdge();
        rdEn = 1'b0;
        stepSample();
        n = 0;
        repeat (8) begin
            if (gS != 0) n++;
            tick();
        end
        check("full_release_grants", n, 1);
        stepEdge();
        rdEn = 1'b1;
        stepSample();
        repeat (20) tick();
        check("full_fifo_empty", 32'(cnt), 0);
        check("full_gnt_left", expGnt.size(), 0);

        // Early release by requester 3 while 0 waits: one bubble, then rrPtr wraps to 0.
        earlyExp = '{4'h8, 4'h8, 4'h0, 4'h1, 4'h1, 4'h0};
        stepEdge();
        remain[3] = 2;
        remain[0] = 2;
        expectWords(3, 2, 1'b1);
        expectWords(0, 2, 1'b1);
        stepSample();
        for (int k = 0; k < 6; k++) begin
            check("early_gnt", 32'(gS), 32'(earlyExp[k]));
            tick();
        end
        repeat (8) tick();

        // Reset in the middle of a burst from requester 2.
        stepEdge();
        remain[2] = 6;
        expectWords(2, 2, 1'b0);
        stepSample();
        check("mb_word1", 32'(gS), 32'h4);
        tick();
        check("mb_word2", 32'(gS), 32'h4);
        stepEdge();
        reset = 1'b0;
        stepSample();
        check("mb_gnt_forced", 32'(gS), 0);
        stepEdge();
        stepSample();
        check("mb_busy", 32'(bus.busy), 0);
        check("mb_gnt", 32'(gS), 0);
        check("mb_wren", 32'(bus.fifoWrEn), 0);
        check("mb_owner", 32'(bus.owner), 0);
        stepEdge();
        reset     = 1'b1;
        remain[0] = 1;
        expectWords(0, 1, 1'b1);
        expectWords(2, 4, 1'b1);
        stepSample();
        check("mb_restart_req0", 32'(gS), 32'h1);
        repeat (14) tick();
        check("mb_fifo_empty", 32'(cnt), 0);
        check("mb_gnt_left", expGnt.size(), 0);
        check("mb_wr_left", expWr.size(), 0);
        check("mb_rd_left", expRd.size(), 0);
        check("no_drops", dropped, 0);

        // MAX_BURST=1 with three requesters: rotate every cycle, never busy.
        for (int k = 0; k < 7; k++) begin
            w = 8'hA0 + 8'(8'h11 * (k % 3));
            exp2Gnt.push_back(k % 3);
            exp2Wr.push_back(w);
        end
        stepEdge();
        reset2 = 1'b1;
        stepSample();
        for (int k = 0; k < 7; k++) begin
            check("mb1_busy", 32'(bus2.busy), 0);
            check("mb1_no_bubble", 32'(bus2.gnt != 0), 1);
            if (k == 6) begin
                stepEdge();
                bus2.req = 3'b000;
                stepSample();
            end else begin
                tick();
            end
        end
        repeat (3) tick();
        check("mb1_gnt_left", exp2Gnt.size(), 0);
        check("mb1_wr_left", exp2Wr.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
